pll_freq_monitor: RTL and testbench

Single-clock frequency monitor for PLL-generated clocks. It counts transitions of a toggle signal produced in the measured clock domain over a fixed gate window of the system clock. It then reports the measured count and a qualified lock/in-range status. It sits next to the PLL wrappers, for example to check that the 27 MHz video clock derived from the 50 MHz board clock is present and on-frequency before video/HDMI logic is released.

---
 rtl/pll_freq_monitor_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 29 ++
 rtl/pll_freq_monitor.sv | 125 ++++++++++++
 tb/tb_pll_freq_monitor.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_freq_monitor_pkg.sv
// Shared types and helpers for the PLL frequency monitor.
// Provides the lock FSM state type and a saturating increment.
package pll_freq_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_QUAL     = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] val,
        input logic [31:0] max_val
    );
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; pulses on any input transition.
// Ports: clk, resetn (sync, active-low), tgl (async input), pulse (1-cycle).
module sync_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic tgl,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= tgl;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    // Both polarities count as one edge.
    assign pulse = sync2 ^ hist;

endmodule

// File: rtl/pll_freq_monitor.sv
// Counts meas_tgl transitions over a fixed clk gate window and qualifies lock.
// Ports: clk, resetn (sync, active-low), meas_tgl (async toggle), count_o,
//        valid_o (close pulse), in_range_o, locked_o, lost_o.
module pll_freq_monitor #(
    parameter int unsigned GATE_CYCLES  = 50000,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned EXP_MIN      = 3300,
    parameter int unsigned EXP_MAX      = 3450,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             meas_tgl,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output logic             in_range_o,
    output logic             locked_o,
    output logic             lost_o
);

    import pll_freq_monitor_pkg::*;

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int QW = $clog2(LOCK_WINDOWS + 1);
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [QW-1:0] QUAL_LAST = QW'(LOCK_WINDOWS - 1);

    logic             edge_pulse;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] closing;
    logic             terminal;
    logic             win_in_range;
    logic             first_win;
    logic [QW-1:0]    qual_cnt;
    lock_state_t      state;

    sync_edge_det u_sync (
        .clk    (clk),
        .resetn (resetn),
        .tgl    (meas_tgl),
        .pulse  (edge_pulse)
    );

    // closing folds in an edge seen on the terminal cycle itself.
    always_comb begin
        terminal = (gate_cnt == GATE_LAST);
        closing  = edge_cnt;
        if (edge_pulse) begin
            closing = CNT_W'(sat_inc(32'(edge_cnt), CNT_MAX));
        end
        win_in_range = (32'(closing) >= EXP_MIN) &&
                       (32'(closing) <= EXP_MAX);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            first_win  <= 1'b1;
            count_o    <= '0;
            valid_o    <= 1'b0;
            in_range_o <= 1'b0;
            lost_o     <= 1'b0;
            locked_o   <= 1'b0;
            qual_cnt   <= '0;
            state      <= ST_UNLOCKED;
        end else begin
            valid_o <= 1'b0;
            if (terminal) begin
                gate_cnt  <= '0;
                edge_cnt  <= '0;
                first_win <= 1'b0;
                // First window may hold a spurious synchronizer edge.
                if (!first_win) begin
                    count_o    <= closing;
                    in_range_o <= win_in_range;
                    lost_o     <= (closing == '0);
                    valid_o    <= 1'b1;
                    unique case (state)
                        ST_UNLOCKED: begin
                            if (win_in_range) begin
                                if (LOCK_WINDOWS == 1) begin
                                    state    <= ST_LOCKED;
                                    locked_o <= 1'b1;
                                end else begin
                                    state    <= ST_QUAL;
                                    qual_cnt <= QW'(1);
                                end
                            end
                        end
                        ST_QUAL: begin
                            if (!win_in_range) begin
                                state    <= ST_UNLOCKED;
                                qual_cnt <= '0;
                            end else if (qual_cnt == QUAL_LAST) begin
                                state    <= ST_LOCKED;
                                qual_cnt <= '0;
                                locked_o <= 1'b1;
                            end else begin
                                qual_cnt <= qual_cnt + QW'(1);
                            end
                        end
                        ST_LOCKED: begin
                            if (!win_in_range || closing == '0) begin
                                state    <= ST_UNLOCKED;
                                locked_o <= 1'b0;
                            end
                        end
                        default: begin
                            state    <= ST_UNLOCKED;
                            qual_cnt <= '0;
                            locked_o <= 1'b0;
                        end
                    endcase
                end
            end else begin
                gate_cnt <= gate_cnt + GW'(1);
                edge_cnt <= closing;
            end
        end
    end

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Self-checking bench for pll_freq_monitor with a window-level reference model.
// Drives two instances: 12-bit main configuration and an 8-bit saturation one.
module tb_pll_freq_monitor;

    localparam int G     = 1000;
    localparam int EMIN  = 245;
    localparam int EMAX  = 255;
    localparam int LOCKW = 3;
    localparam int MAXC  = 4095;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        meas_tgl = 1'b0;
    logic [11:0] count_o;
    logic        valid_o, in_range_o, locked_o, lost_o;

    logic        resetn_b = 1'b0;
    logic        meas_b = 1'b0;
    logic [7:0]  count_b;
    logic        valid_b, in_range_b, locked_b, lost_b;

    always #5 clk = ~clk;

    pll_freq_monitor #(
        .GATE_CYCLES(G), .CNT_W(12), .EXP_MIN(EMIN),
        .EXP_MAX(EMAX), .LOCK_WINDOWS(LOCKW)
    ) dut (
        .clk(clk), .resetn(resetn), .meas_tgl(meas_tgl),
        .count_o(count_o), .valid_o(valid_o), .in_range_o(in_range_o),
        .locked_o(locked_o), .lost_o(lost_o)
    );

    // Saturation instance: range kept below 255 so a saturated count is out-of-range.
    pll_freq_monitor #(
        .GATE_CYCLES(G), .CNT_W(8), .EXP_MIN(245),
        .EXP_MAX(250), .LOCK_WINDOWS(LOCKW)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .meas_tgl(meas_b),
        .count_o(count_b), .valid_o(valid_b), .in_range_o(in_range_b),
        .locked_o(locked_b), .lost_o(lost_b)
    );

    int total = 0;
    int bad = 0;

    // Reference model: edges binned by the window they fall in, lock as a run length.
    int   cyc;
    int   ph;
    int   win_cnt[int];
    int   run;
    int   ec;
    logic ev, er, elost, el;

    task automatic model_clear();
        cyc = 0;
        ph = 0;
        win_cnt.delete();
        run = 0;
        ec = 0;
        ev = 1'b0;
        er = 1'b0;
        elost = 1'b0;
        el = 1'b0;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        resetn = 1'b1;
    endtask

    // p > 0: toggle every p cycles; p == 0: hold; p < 0: single toggle now.
    task automatic step(input int p);
        int w, n, k;
        @(posedge clk);
        cyc++;
        #1;
        ev = 1'b0;
        if (cyc % G == 0 && cyc / G >= 2) begin
            w = cyc / G - 1;
            n = win_cnt.exists(w) ? win_cnt[w] : 0;
            ev = 1'b1;
            ec = (n > MAXC) ? MAXC : n;
            er = (ec >= EMIN) && (ec <= EMAX);
            elost = (ec == 0);
            run = er ? run + 1 : 0;
            el = (run >= LOCKW);
        end
        if (p > 0) ph++;
        if (p < 0 || (p > 0 && ph >= p)) begin
            ph = 0;
            meas_tgl = ~meas_tgl;
            // Sampled twice by the synchronizer, counted on the third edge.
            k = (cyc + 2) / G;
            if (!win_cnt.exists(k)) win_cnt[k] = 0;
            win_cnt[k] = win_cnt[k] + 1;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({valid_o, in_range_o, lost_o, locked_o, count_o} !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0000",
                     {valid_o, in_range_o, lost_o, locked_o, count_o});
        end
        repeat (2500) begin
            step(3);
            total++;
            if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                {ev, er, elost, el, ec[11:0]}) begin
                bad++;
                $display("FAIL reset_run cyc=%0d got=%h exp=%h", cyc,
                         {valid_o, in_range_o, lost_o, locked_o, count_o},
                         {ev, er, elost, el, ec[11:0]});
            end
        end
        total++;
        if (count_o !== 12'd333) begin
            bad++;
            $display("FAIL period3_count got=%0d exp=333", count_o);
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({valid_o, in_range_o, lost_o, locked_o, count_o} !== 16'h0) begin
            bad++;
            $display("FAIL midwin_reset got=%h exp=0000",
                     {valid_o, in_range_o, lost_o, locked_o, count_o});
        end
    endtask

    task automatic test_lock_basic();
        apply_reset();
        repeat (4000) begin
            step(4);
            total++;
            if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                {ev, er, elost, el, ec[11:0]}) begin
                bad++;
                $display("FAIL lock_basic cyc=%0d got=%h exp=%h", cyc,
                         {valid_o, in_range_o, lost_o, locked_o, count_o},
                         {ev, er, elost, el, ec[11:0]});
            end
        end
        total++;
        if (count_o !== 12'd250 || locked_o !== 1'b1 || in_range_o !== 1'b1) begin
            bad++;
            $display("FAIL lock_third_close got count=%0d lock=%b exp count=250 lock=1",
                     count_o, locked_o);
        end
    endtask

    task automatic test_out_of_range();
        repeat (2000) begin
            step(5);
            total++;
            if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                {ev, er, elost, el, ec[11:0]}) begin
                bad++;
                $display("FAIL out_of_range cyc=%0d got=%h exp=%h", cyc,
                         {valid_o, in_range_o, lost_o, locked_o, count_o},
                         {ev, er, elost, el, ec[11:0]});
            end
        end
        total++;
        if (count_o !== 12'd200 || in_range_o !== 1'b0 || locked_o !== 1'b0) begin
            bad++;
            $display("FAIL period5_count got count=%0d rng=%b lock=%b exp 200/0/0",
                     count_o, in_range_o, locked_o);
        end
    endtask

    task automatic test_lost_relock();
        apply_reset();
        for (int ph_i = 0; ph_i < 3; ph_i++) begin
            repeat (ph_i == 1 ? 2000 : 4000) begin
                step(ph_i == 1 ? 0 : 4);
                total++;
                if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                    {ev, er, elost, el, ec[11:0]}) begin
                    bad++;
                    $display("FAIL lost_relock cyc=%0d got=%h exp=%h", cyc,
                             {valid_o, in_range_o, lost_o, locked_o, count_o},
                             {ev, er, elost, el, ec[11:0]});
                end
            end
            if (ph_i == 1) begin
                total++;
                if (count_o !== 12'd0 || lost_o !== 1'b1 || locked_o !== 1'b0) begin
                    bad++;
                    $display("FAIL lost_flag got count=%0d lost=%b lock=%b exp 0/1/0",
                             count_o, lost_o, locked_o);
                end
            end
        end
        total++;
        if (locked_o !== 1'b1) begin
            bad++;
            $display("FAIL relock got=%b exp=1", locked_o);
        end
    endtask

    task automatic test_requal();
        int pl[4] = '{4, 5, 4, 4};
        int nl[4] = '{3000, 1000, 2000, 1000};
        apply_reset();
        for (int s = 0; s < 4; s++) begin
            repeat (nl[s]) begin
                step(pl[s]);
                total++;
                if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                    {ev, er, elost, el, ec[11:0]}) begin
                    bad++;
                    $display("FAIL requal cyc=%0d got=%h exp=%h", cyc,
                             {valid_o, in_range_o, lost_o, locked_o, count_o},
                             {ev, er, elost, el, ec[11:0]});
                end
            end
            if (s == 2) begin
                total++;
                if (locked_o !== 1'b0) begin
                    bad++;
                    $display("FAIL requal_two_good got=%b exp=0", locked_o);
                end
            end
        end
        total++;
        if (locked_o !== 1'b1) begin
            bad++;
            $display("FAIL requal_three_good got=%b exp=1", locked_o);
        end
    endtask

    task automatic test_terminal_edge();
        int pat_n[6] = '{2996, 1, 3, 997, 1, 1002};
        int pat_p[6] = '{0, -1, 0, 0, -1, 0};
        apply_reset();
        for (int s = 0; s < 6; s++) begin
            repeat (pat_n[s]) begin
                step(pat_p[s]);
                total++;
                if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                    {ev, er, elost, el, ec[11:0]}) begin
                    bad++;
                    $display("FAIL terminal_edge cyc=%0d got=%h exp=%h", cyc,
                             {valid_o, in_range_o, lost_o, locked_o, count_o},
                             {ev, er, elost, el, ec[11:0]});
                end
            end
            if (s == 2) begin
                total++;
                if (valid_o !== 1'b1 || count_o !== 12'd1 || lost_o !== 1'b0) begin
                    bad++;
                    $display("FAIL terminal_in got v=%b count=%0d exp v=1 count=1",
                             valid_o, count_o);
                end
            end
        end
        total++;
        if (count_o !== 12'd1) begin
            bad++;
            $display("FAIL after_terminal got=%0d exp=1", count_o);
        end
    endtask

    task automatic test_saturation();
        int nb[int];
        int cb, k, e;
        logic evb;
        for (int s = 0; s < 2; s++) begin
            resetn_b = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            total++;
            if ({valid_b, in_range_b, lost_b, locked_b, count_b} !== 12'h0) begin
                bad++;
                $display("FAIL sat_reset got=%h exp=000",
                         {valid_b, in_range_b, lost_b, locked_b, count_b});
            end
            resetn_b = 1'b1;
            nb.delete();
            cb = 0;
            e = 0;
            repeat (s == 0 ? 2500 : 2100) begin
                @(posedge clk);
                cb++;
                #1;
                evb = (cb % G == 0) && (cb / G >= 2);
                if (evb) begin
                    k = cb / G - 1;
                    e = nb.exists(k) ? nb[k] : 0;
                    if (e > 255) e = 255;
                end
                total++;
                if ({valid_b, in_range_b, lost_b, locked_b, count_b} !==
                    {evb, (e >= 245 && e <= 250), (cb >= 2000 && e == 0), 1'b0, e[7:0]}) begin
                    bad++;
                    $display("FAIL saturation cyc=%0d got=%h exp=%h", cb,
                             {valid_b, in_range_b, lost_b, locked_b, count_b},
                             {evb, (e >= 245 && e <= 250), (cb >= 2000 && e == 0),
                              1'b0, e[7:0]});
                end
                if (cb % 2 == 0) begin
                    meas_b = ~meas_b;
                    k = (cb + 2) / G;
                    if (!nb.exists(k)) nb[k] = 0;
                    nb[k] = nb[k] + 1;
                end
            end
            total++;
            if (count_b !== 8'd255) begin
                bad++;
                $display("FAIL sat_value got=%0d exp=255", count_b);
            end
        end
    endtask

    task automatic test_random();
        int pt[8] = '{4, 4, 4, 4, 5, 3, 2, 0};
        int p, len, q;
        apply_reset();
        for (int s = 0; s < 14; s++) begin
            p = pt[$urandom_range(0, 7)];
            len = $urandom_range(500, 3500);
            repeat (len) begin
                q = p;
                if (p == 0 && $urandom_range(0, 299) == 0) q = -1;
                step(q);
                total++;
                if ({valid_o, in_range_o, lost_o, locked_o, count_o} !==
                    {ev, er, elost, el, ec[11:0]}) begin
                    bad++;
                    $display("FAIL random cyc=%0d got=%h exp=%h", cyc,
                             {valid_o, in_range_o, lost_o, locked_o, count_o},
                             {ev, er, elost, el, ec[11:0]});
                end
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_lock_basic();
        test_out_of_range();
        test_lost_relock();
        test_requal();
        test_terminal_edge();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
